// File: rtl/mux_arbiter_if.sv
// Handshake and payload bundle between N_CH producers and one registered output stage.
// "master" is the side driving channel data and the downstream ready; "slave" is the arbiter.
interface mux_arbiter_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = (N_CH > 2) ? $clog2(N_CH) : 1
);
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_ready;
    logic [SEL_W-1:0]       sel;
    logic [1:0]             mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;

    modport master (
        output in_valid, in_data, sel, mode, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, sel, mode, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_arbiter.sv
// N-channel arbitrating mux (steered / fixed-priority / round-robin) feeding a single
// output register with valid/ready handshake and full one-transfer-per-cycle throughput.
module mux_arbiter #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    mux_arbiter_if.slave io
);
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [SEL_W-1:0]  out_ch_r;
    logic [SEL_W-1:0]  rr_ptr_r;

    logic              load_en_s;
    logic              grant_hit_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic [N_CH-1:0]   grant_vec_s;
    logic              xfer_s;
    logic [SEL_W-1:0]  rr_next_s;

    // Output register may load when empty or being drained on this edge
    assign load_en_s = !out_valid_r || io.out_ready;

    // Channel selection; searches run high-to-low so the earliest candidate in order wins
    always_comb begin
        grant_hit_s = 1'b0;
        grant_idx_s = '0;
        case (io.mode)
            2'd0: begin
                if (int'(io.sel) < N_CH) begin
                    grant_hit_s = io.in_valid[io.sel];
                    grant_idx_s = io.sel;
                end else begin
                    grant_hit_s = 1'b0;
                    grant_idx_s = '0;
                end
            end
            2'd2: begin
                for (int k = N_CH - 1; k >= 0; k--) begin
                    grant_idx_s = io.in_valid[(int'(rr_ptr_r) + k) % N_CH]
                                ? SEL_W'((int'(rr_ptr_r) + k) % N_CH) : grant_idx_s;
                    grant_hit_s = grant_hit_s | io.in_valid[(int'(rr_ptr_r) + k) % N_CH];
                end
            end
            default: begin
                for (int k = N_CH - 1; k >= 0; k--) begin
                    grant_idx_s = io.in_valid[k] ? SEL_W'(k) : grant_idx_s;
                    grant_hit_s = grant_hit_s | io.in_valid[k];
                end
            end
        endcase
    end

    // One-hot grant vector and transfer qualification
    always_comb begin
        grant_vec_s = '0;
        if (grant_hit_s) begin
            grant_vec_s[grant_idx_s] = 1'b1;
        end else begin
            grant_vec_s = '0;
        end
        if (grant_idx_s == SEL_W'(N_CH - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_idx_s + SEL_W'(1);
        end
    end

    // Reset is folded in so ready is low immediately while reset is held
    assign io.in_ready = grant_vec_s & {N_CH{load_en_s & reset}};
    assign xfer_s      = grant_hit_s & load_en_s;

    // Output register and round-robin pointer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            rr_ptr_r    <= '0;
        end else begin
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= io.in_data[int'(grant_idx_s) * DATA_W +: DATA_W];
                out_ch_r    <= grant_idx_s;
            end else if (io.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (xfer_s && (io.mode == 2'd2)) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;
    assign io.out_ch    = out_ch_r;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed-vector bench for mux_arbiter: an 8-channel instance for the main scenarios
// and a 6-channel instance for the out-of-range steered select.
module tb_mux_arbiter;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mux_arbiter_if #(.N_CH(8), .DATA_W(8)) m8 ();
    mux_arbiter_if #(.N_CH(6), .DATA_W(8)) m6 ();

    mux_arbiter #(.N_CH(8), .DATA_W(8)) dut8 (.clock(clock), .reset(reset), .io(m8.slave));
    mux_arbiter #(.N_CH(6), .DATA_W(8)) dut6 (.clock(clock), .reset(reset), .io(m6.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
        chk({tag, "_valid"}, 32'(m8.out_valid), 32'(v));
        chk({tag, "_data"},  32'(m8.out_data),  32'(d));
        chk({tag, "_ch"},    32'(m8.out_ch),    32'(c));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        for (int i = 0; i < 8; i++) m8.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        m8.in_valid = 8'hFF;
        m8.sel = 3'd0;
        m8.mode = 2'd1;
        m8.out_ready = 1'b1;
        m6.in_valid = 6'h00;
        m6.in_data = 48'h0;
        m6.sel = 3'd0;
        m6.mode = 2'd0;
        m6.out_ready = 1'b1;

        // Reset state held across edges, ready forced low
        #3;
        chk("rst_ready", 32'(m8.in_ready), 32'h0);
        step();
        step();
        chk_out("rst", 1'b0, 8'h00, 3'd0);
        chk("rst_ready2", 32'(m8.in_ready), 32'h0);
        m8.in_valid = 8'h00;
        @(negedge clock);
        reset = 1'b1;

        // Fixed priority picks lowest valid channel
        m8.mode = 2'd1;
        m8.in_valid = 8'h28;
        #1;
        chk("fp_ready", 32'(m8.in_ready), 32'h08);
        step();
        chk_out("fp_out", 1'b1, 8'hA3, 3'd3);
        m8.in_valid = 8'h00;
        step();
        chk_out("fp_drain", 1'b0, 8'hA3, 3'd3);

        // Round-robin with all channels valid: 0..7 then wrap to 0
        m8.mode = 2'd2;
        m8.in_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("rr_ready%0d", k), 32'(m8.in_ready), 32'(8'h01 << (k % 8)));
            step();
            chk($sformatf("rr_ch%0d", k), 32'(m8.out_ch), 32'(k % 8));
            chk($sformatf("rr_data%0d", k), 32'(m8.out_data), 32'(8'hA0 + 8'(k % 8)));
        end
        // Three more round-robin grants leave the pointer at 4
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("rr_more%0d", k), 32'(m8.out_ch), 32'(k));
        end

        // Two fixed-priority transfers must not move the pointer
        m8.mode = 2'd1;
        step();
        chk("fp_keep1", 32'(m8.out_ch), 32'd0);
        step();
        chk("fp_keep2", 32'(m8.out_ch), 32'd0);
        m8.mode = 2'd2;
        m8.in_valid = 8'h44;
        #1;
        chk("rr_resume_ready", 32'(m8.in_ready), 32'h40);
        step();
        chk_out("rr_resume", 1'b1, 8'hA6, 3'd6);
        m8.in_valid = 8'h00;
        step();
        chk("rr_idle_valid", 32'(m8.out_valid), 32'd0);

        // Steered mode with backpressure
        m8.mode = 2'd0;
        m8.sel = 3'd5;
        m8.in_valid = 8'h20;
        m8.out_ready = 1'b0;
        #1;
        chk("st_ready", 32'(m8.in_ready), 32'h20);
        step();
        chk_out("st_load", 1'b1, 8'hA5, 3'd5);
        m8.in_data[5*8 +: 8] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) m8.mode = 2'd1;
            #1;
            chk($sformatf("st_hold_ready%0d", k), 32'(m8.in_ready), 32'h0);
            step();
            chk_out($sformatf("st_hold%0d", k), 1'b1, 8'hA5, 3'd5);
        end
        m8.mode = 2'd0;
        m8.out_ready = 1'b1;
        #1;
        chk("st_release_ready", 32'(m8.in_ready), 32'h20);
        step();
        chk_out("st_reload", 1'b1, 8'h5A, 3'd5);
        m8.in_valid = 8'h00;
        step();
        chk("st_drain", 32'(m8.out_valid), 32'd0);

        // Mode 3 behaves as fixed priority
        m8.mode = 2'd3;
        m8.in_valid = 8'h30;
        #1;
        chk("m3_ready", 32'(m8.in_ready), 32'h10);
        m8.in_valid = 8'h00;

        // Six-channel instance: steered select beyond channel count grants nothing
        m6.mode = 2'd0;
        m6.sel = 3'd7;
        m6.in_valid = 6'h3F;
        #1;
        chk("n6_ready", 32'(m6.in_ready), 32'h0);
        step();
        chk("n6_valid", 32'(m6.out_valid), 32'd0);
        m6.sel = 3'd2;
        #1;
        chk("n6_sel2_ready", 32'(m6.in_ready), 32'h04);
        m6.in_valid = 6'h00;

        // Round-robin from pointer 7 with only channel 3 valid, then async reset mid-hold
        m8.mode = 2'd2;
        m8.in_valid = 8'h08;
        step();
        chk_out("pre_rst", 1'b1, 8'hA3, 3'd3);
        m8.out_ready = 1'b0;
        m8.in_valid = 8'hFF;
        #2;
        reset = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 8'h00, 3'd0);
        chk("async_rst_ready", 32'(m8.in_ready), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        m8.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(m8.in_ready), 32'h01);
        step();
        chk_out("post_rst", 1'b1, 8'hA0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
